// File: rtl/aes_enc_iter_core.sv
// aes_enc_iter_core
//   Iterative AES encryption core. One round per clock, AES-128 or AES-256
//   chosen by KEY_BITS, with round keys expanded on the fly. A loaded key is
//   retained and reused for later blocks until a new one is loaded.
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous reset, active high
//   in_valid     block request
//   in_ready     request can be accepted this cycle
//   in_key_load  1 = load in_key as the new cipher key, 0 = reuse stored key
//   in_key       cipher key, byte 0 in the MSBs
//   in_block     plaintext, byte 0 in bits [127:120]
//   out_valid    out_block holds a finished ciphertext
//   out_ready    sink accepts out_block
//   out_block    ciphertext, held while out_valid && !out_ready
module aes_enc_iter_core #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_key_load,
  input  logic [KEY_BITS-1:0] in_key,
  input  logic [127:0]        in_block,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_block
);

  localparam int NR = (KEY_BITS == 256) ? 14 : 10;
  localparam logic [3:0] NR_L = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_enc_iter_core: KEY_BITS must be 128 or 256");
  end

  // S-box, byte 0x00 in the top byte.
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits at bit offset 8*(255-b), which is {~b, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_FLAT[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] rc;
    case (i)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    return {sub_word(s[127:96]), sub_word(s[95:64]), sub_word(s[63:32]), sub_word(s[31:0])};
  endfunction

  // Row r rotates left by r; bytes are column-major (byte r + 4c).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    return {s[127:120], s[87:80],   s[47:40],   s[7:0],
            s[95:88],   s[55:48],   s[15:8],    s[103:96],
            s[63:56],   s[23:16],   s[111:104], s[71:64],
            s[31:24],   s[119:112], s[79:72],   s[39:32]};
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24]; a1 = w[23:16]; a2 = w[15:8]; a3 = w[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_column(s[127:96]), mix_column(s[95:64]),
            mix_column(s[63:32]),  mix_column(s[31:0])};
  endfunction

  function automatic logic [127:0] expand128(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Next four AES-256 schedule words from the previous two round keys.
  function automatic logic [127:0] expand256(input logic [127:0] prev, input logic [127:0] curr,
                                             input logic even, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = even ? (sub_word(rot_word(curr[31:0])) ^ {rc, 24'h0}) : sub_word(curr[31:0]);
    n0 = prev[127:96] ^ t;
    n1 = prev[95:64]  ^ n0;
    n2 = prev[63:32]  ^ n1;
    n3 = prev[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

  fsm_t                fsm_q;
  logic [3:0]          r_q;
  logic [KEY_BITS-1:0] key_q;
  logic [127:0]        state_q;
  logic                out_valid_q;
  logic [127:0]        out_block_q;

  logic                accept;
  logic                run;
  logic [KEY_BITS-1:0] eff_key;
  logic [127:0]        rk0;
  logic [127:0]        rk_cur;
  logic [127:0]        round_sr;
  logic [127:0]        round_d;

  // In DONE the sink's ready passes straight through so a new block can be
  // taken on the same edge the finished one is consumed.
  assign in_ready  = !reset && ((fsm_q == S_IDLE) || (fsm_q == S_DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign run       = (fsm_q == S_RUN);
  assign eff_key   = in_key_load ? in_key : key_q;
  assign out_valid = out_valid_q;
  assign out_block = out_block_q;

  assign round_sr = shift_rows(sub_bytes(state_q));
  assign round_d  = ((r_q == NR_L) ? round_sr : mix_columns(round_sr)) ^ rk_cur;

  if (KEY_BITS == 128) begin : g_ks128
    logic [127:0] wk_q;

    assign rk0    = eff_key;
    assign rk_cur = expand128(wk_q, rcon(r_q));

    always_ff @(posedge clk) begin
      if (reset)       wk_q <= '0;
      else if (accept) wk_q <= eff_key;
      else if (run)    wk_q <= rk_cur;
    end
  end else begin : g_ks256
    logic [127:0] prev_q, curr_q;
    logic [127:0] rk_new;

    assign rk0    = eff_key[255:128];
    assign rk_new = expand256(prev_q, curr_q, ~r_q[0], rcon({1'b0, r_q[3:1]}));
    // Round 1 uses the second key half directly; expansion starts at round 2.
    assign rk_cur = (r_q == 4'd1) ? curr_q : rk_new;

    always_ff @(posedge clk) begin
      if (reset) begin
        prev_q <= '0;
        curr_q <= '0;
      end else if (accept) begin
        prev_q <= eff_key[255:128];
        curr_q <= eff_key[127:0];
      end else if (run && r_q != 4'd1) begin
        prev_q <= curr_q;
        curr_q <= rk_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= S_IDLE;
      r_q         <= '0;
      key_q       <= '0;
      state_q     <= '0;
      out_valid_q <= 1'b0;
      out_block_q <= '0;
    end else if (accept) begin
      if (in_key_load) key_q <= in_key;
      state_q     <= in_block ^ rk0;
      r_q         <= 4'd1;
      out_valid_q <= 1'b0;
      fsm_q       <= S_RUN;
    end else begin
      unique case (fsm_q)
        S_IDLE: ;
        S_RUN: begin
          state_q <= round_d;
          if (r_q == NR_L) begin
            out_block_q <= round_d;
            out_valid_q <= 1'b1;
            r_q         <= '0;
            fsm_q       <= S_DONE;
          end else begin
            r_q <= r_q + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            fsm_q       <= S_IDLE;
          end
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_enc_iter_core.sv
module tb_aes_enc_iter_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic         a_in_valid, a_in_ready, a_key_load, a_out_valid, a_out_ready;
  logic [127:0] a_key, a_block, a_out_block;
  logic         b_in_valid, b_in_ready, b_key_load, b_out_valid, b_out_ready;
  logic [255:0] b_key;
  logic [127:0] b_block, b_out_block;

  aes_enc_iter_core #(.KEY_BITS(128)) u_dut128 (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_key_load(a_key_load),
    .in_key(a_key), .in_block(a_block),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_block(a_out_block)
  );

  aes_enc_iter_core #(.KEY_BITS(256)) u_dut256 (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_key_load(b_key_load),
    .in_key(b_key), .in_block(b_block),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_block(b_out_block)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  logic [7:0] sb_m [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic init_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] xb, inv, s;
      xb  = 8'(x);
      inv = 8'h00;
      if (xb != 8'h00) begin
        inv = xb;
        for (int k = 0; k < 253; k++) inv = gmul(inv, xb);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb_m[x] = s;
    end
  endtask

  function automatic logic [31:0] sw_m(input logic [31:0] w);
    return {sb_m[w[31:24]], sb_m[w[23:16]], sb_m[w[15:8]], sb_m[w[7:0]]};
  endfunction

  // key is left-aligned: AES-128 keys occupy [255:128].
  function automatic logic [127:0] aes_ref(input logic [255:0] key, input int nk,
                                           input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [255:0] k;
    logic [127:0] p, o;
    logic [31:0]  tmp, wd;
    logic [7:0]   rc, a0, a1, a2, a3;
    int           nr;
    nr = nk + 6;
    k  = key;
    for (int i = 0; i < nk; i++) begin
      w[i] = k[255:224];
      k    = k << 32;
    end
    rc = 8'h01;
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = sw_m({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = sw_m(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    p = pt;
    for (int i = 0; i < 16; i++) begin
      s[i] = p[127:120];
      p    = p << 8;
    end
    for (int rnd = 0; rnd <= nr; rnd++) begin
      if (rnd > 0) begin
        for (int i = 0; i < 16; i++) s[i] = sb_m[s[i]];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) t[r + 4*c] = s[r + 4*((c + r) % 4)];
        s = t;
        if (rnd < nr) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
          end
        end
      end
      for (int c = 0; c < 4; c++) begin
        wd = w[4*rnd + c];
        s[4*c]   = s[4*c]   ^ wd[31:24];
        s[4*c+1] = s[4*c+1] ^ wd[23:16];
        s[4*c+2] = s[4*c+2] ^ wd[15:8];
        s[4*c+3] = s[4*c+3] ^ wd[7:0];
      end
    end
    o = '0;
    for (int i = 0; i < 16; i++) o = {o[119:0], s[i]};
    return o;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [135:0] got, input logic [135:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic ov(input bit sel);
    return sel ? b_out_valid : a_out_valid;
  endfunction

  function automatic logic [127:0] ob(input bit sel);
    return sel ? b_out_block : a_out_block;
  endfunction

  task automatic scramble();
    a_in_valid = 1'b0; a_key_load = 1'($urandom);
    a_key   = {$urandom, $urandom, $urandom, $urandom};
    a_block = {$urandom, $urandom, $urandom, $urandom};
    b_in_valid = 1'b0; b_key_load = 1'($urandom);
    b_key   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b_block = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Called at a negedge with the target core idle; returns at the negedge
  // right after the accept edge.
  task automatic request(input bit sel, input string name, input logic [255:0] key,
                         input bit load, input logic [127:0] pt);
    chk({name, " in_ready"}, 136'(sel ? b_in_ready : a_in_ready), 136'(1));
    if (!sel) begin
      a_in_valid = 1'b1; a_key_load = load; a_key = key[255:128]; a_block = pt;
    end else begin
      b_in_valid = 1'b1; b_key_load = load; b_key = key; b_block = pt;
    end
    @(negedge clk);
    scramble();
  endtask

  task automatic wait_done(input bit sel, input string name, input logic [127:0] exp,
                           input int nr);
    int n;
    n = 0;
    while (!ov(sel) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, " latency"}, 136'(n), 136'(nr));
    chk({name, " block"}, 136'(ob(sel)), 136'(exp));
  endtask

  task automatic consume(input bit sel, input string name);
    if (sel) b_out_ready = 1'b1; else a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0; b_out_ready = 1'b0;
    chk({name, " consumed"}, 136'(ov(sel)), 136'(0));
  endtask

  typedef struct {
    bit           sel;
    logic [255:0] key;
    bit           load;
    logic [127:0] pt;
    logic [127:0] exp;
    string        name;
  } vec_t;

  vec_t vecs [7];

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K2  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] KF  = {128'hffffffffffffffffffffffffffffffff, 128'h0};

  task automatic set_vec(input int i, input bit sel, input logic [255:0] key, input bit load,
                         input logic [127:0] pt, input logic [127:0] exp, input string name);
    vecs[i].sel = sel; vecs[i].key = key; vecs[i].load = load;
    vecs[i].pt = pt; vecs[i].exp = exp; vecs[i].name = name;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    logic [127:0] exp_bp;
    init_sbox();
    set_vec(0, 1'b0, {K1, 128'h0}, 1'b1, P1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, "c1_128");
    set_vec(1, 1'b0, {KB, 128'h0}, 1'b1, PB, 128'h3925841d02dc09fbdc118597196a0b32, "appb_load");
    set_vec(2, 1'b0, {K1, 128'h0}, 1'b0, P1, aes_ref({KB, 128'h0}, 4, P1), "retain_c1pt");
    set_vec(3, 1'b0, {K1, 128'h0}, 1'b0, PB, 128'h3925841d02dc09fbdc118597196a0b32, "retain_appb");
    set_vec(4, 1'b1, K2, 1'b1, P1, 128'h8ea2b7ca516745bfeafc49904b496089, "c3_256");
    set_vec(5, 1'b1, ~K2, 1'b0, PB, aes_ref(K2, 8, PB), "retain_256");
    set_vec(6, 1'b0, KF, 1'b1, 128'h0, aes_ref(KF, 4, 128'h0), "ones_key");

    reset = 1'b1;
    scramble();
    a_out_ready = 1'b0; b_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst in_ready a", 136'(a_in_ready), 136'(0));
    chk("rst out_valid a", 136'(a_out_valid), 136'(0));
    chk("rst out_block a", 136'(a_out_block), 136'(0));
    chk("rst in_ready b", 136'(b_in_ready), 136'(0));
    chk("rst out_valid b", 136'(b_out_valid), 136'(0));
    chk("rst out_block b", 136'(b_out_block), 136'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("post-rst in_ready a", 136'(a_in_ready), 136'(1));
    chk("post-rst in_ready b", 136'(b_in_ready), 136'(1));

    for (int i = 0; i < 7; i++) begin
      request(vecs[i].sel, vecs[i].name, vecs[i].key, vecs[i].load, vecs[i].pt);
      wait_done(vecs[i].sel, vecs[i].name, vecs[i].exp, vecs[i].sel ? 14 : 10);
      consume(vecs[i].sel, vecs[i].name);
    end

    // Backpressure: hold done for 20 cycles with a pending request.
    request(1'b0, "bp_first", {K1, 128'h0}, 1'b1, P1);
    wait_done(1'b0, "bp_first", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10);
    a_in_valid = 1'b1; a_key_load = 1'b0; a_block = PB;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp hold {valid,in_ready,block}", {7'd0, a_out_valid, a_in_ready, a_out_block},
          {7'd0, 1'b1, 1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a});
    end
    a_out_ready = 1'b1;
    #1;
    chk("bp in_ready follows out_ready", 136'(a_in_ready), 136'(1));
    @(negedge clk);
    a_out_ready = 1'b0;
    scramble();
    chk("bp out_valid drops", 136'(a_out_valid), 136'(0));
    exp_bp = aes_ref({K1, 128'h0}, 4, PB);
    wait_done(1'b0, "bp_second", exp_bp, 10);
    consume(1'b0, "bp_second");

    // Reset at round 5 clears the stored key and discards the block.
    request(1'b0, "abort", {KB, 128'h0}, 1'b1, P1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort in_ready in reset", 136'(a_in_ready), 136'(0));
    @(negedge clk);
    chk("abort out_valid", 136'(a_out_valid), 136'(0));
    reset = 1'b0;
    #1;
    chk("abort in_ready after", 136'(a_in_ready), 136'(1));
    @(negedge clk);
    request(1'b0, "zero_key", {K1, 128'h0}, 1'b0, P1);
    wait_done(1'b0, "zero_key", aes_ref(256'h0, 4, P1), 10);
    consume(1'b0, "zero_key");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
